// File: rtl/arb_mux_nx1.sv
// arb_mux_nx1: registered N:1 selector with valid/ready channels and round-robin or fixed-priority arbitration
module arb_mux_nx1 #(
  parameter int WIDTH = 32,
  parameter int N     = 8,
  parameter int RR    = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N*WIDTH-1:0]     in_data,
  input  logic [N-1:0]           in_valid,
  output logic [N-1:0]           in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  output logic [$clog2(N)-1:0]   out_sel,
  input  logic                   out_ready
);
  localparam int SELW = $clog2(N);
  logic [SELW-1:0]  r_ptr, r_sel, w_g, w_nxt;
  logic [WIDTH-1:0] r_data, w_word;
  logic             r_valid, w_hit, w_free;
  // Scan from ptr downwards in priority so the first valid channel after ptr is the last assignment
  always_comb begin
    w_g   = '0;
    w_hit = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (in_valid[(int'(r_ptr) + k) % N]) begin
        w_g   = SELW'((int'(r_ptr) + k) % N);
        w_hit = 1'b1;
      end
    end
  end
  assign w_free    = !r_valid || out_ready;
  assign in_ready  = (rst_n && w_free && w_hit) ? (N'(1'b1) << w_g) : '0;
  assign w_word    = in_data[int'(w_g)*WIDTH +: WIDTH];
  assign w_nxt     = (w_g == SELW'(N - 1)) ? '0 : w_g + 1'b1;
  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign out_sel   = r_sel;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
    end else if (w_free) begin
      r_valid <= w_hit;
      if (w_hit) begin
        r_data <= w_word;
        r_sel  <= w_g;
        if (RR != 0) r_ptr <= w_nxt;
      end
    end
  end
endmodule
